// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl
//
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits that
// share one registered hex-to-seven-segment decoder. Each digit slot is
// BLANK_CYCLES with every digit off (covering the decoder's register
// latency), followed by DWELL_CYCLES with that digit's enable low. Display
// values are double-buffered: loads made while scanning land in a pending
// register and are copied to the shadow register only at a frame boundary.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_value        display value, nibble k drives digit k (digit 0 = LSN)
//   i_load         one-cycle strobe requesting i_value be displayed
//   i_enable       scan enable; low forces all digits off
//   o_load_ack     one-cycle pulse when a new value enters the shadow register
//   o_digit_value  nibble presented to the decoder
//   o_digit_en     active-low digit enables, at most one low at a time
//   o_frame_start  one-cycle pulse on the first blank cycle of digit 0
//
// Build option:
//   SEVEN_SEG_SCAN_LZ_BLANK_EN  when defined, digits k>0 stay dark during
//                               their slot if shadow nibbles k..NUM_DIGITS-1
//                               are all zero (leading-zero blanking).
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_load,
    input  logic                    i_enable,
    output logic                    o_load_ack,
    output logic [3:0]              o_digit_value,
    output logic [NUM_DIGITS-1:0]   o_digit_en,
    output logic                    o_frame_start
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF    = '1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        index;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;

    logic [IDX_W-1:0]        index_next;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] shadow_upd;
    logic                    upd_ack;
    logic                    lz_dark;
    logic [NUM_DIGITS-1:0]   drive_en;

    function automatic logic [3:0] nibble(input logic [4*NUM_DIGITS-1:0] v,
                                          input logic [IDX_W-1:0]        idx);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) r = v[4*k +: 4];
        end
        return r;
    endfunction

    assign index_next = (index == LAST_IDX) ? '0 : index + 1'b1;

    // Last DRIVE cycle of the last digit while still enabled: the only point
    // at which the shadow register may change during scanning.
    assign frame_end = (state == DRIVE) && i_enable && (cnt == DWELL_LAST) &&
                       (index == LAST_IDX);

    // Candidate shadow contents when a transfer is allowed (IDLE or frame
    // end): a load in the same cycle beats an older pending value.
    assign shadow_upd = i_load ? i_value : (pending_valid ? pending : shadow);
    assign upd_ack    = i_load | pending_valid;

`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
    always_comb begin
        lz_dark = 1'b0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (index == IDX_W'(k) && (shadow >> (4*k)) == '0) lz_dark = 1'b1;
        end
    end
`else
    assign lz_dark = 1'b0;
`endif

    always_comb begin
        drive_en = ALL_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index == IDX_W'(k)) drive_en[k] = 1'b0;
        end
        if (lz_dark) drive_en = ALL_OFF;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            index         <= '0;
            shadow        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            o_load_ack    <= 1'b0;
            o_frame_start <= 1'b0;
            o_digit_value <= 4'h0;
            o_digit_en    <= ALL_OFF;
        end else begin
            o_load_ack    <= 1'b0;
            o_frame_start <= 1'b0;

            case (state)
                IDLE: begin
                    o_digit_en <= ALL_OFF;
                    if (upd_ack) begin
                        shadow        <= shadow_upd;
                        o_load_ack    <= 1'b1;
                        pending_valid <= 1'b0;
                    end
                    if (i_enable) begin
                        state         <= BLANK;
                        index         <= '0;
                        cnt           <= '0;
                        o_frame_start <= 1'b1;
                        o_digit_value <= nibble(shadow_upd, '0);
                    end
                end

                BLANK: begin
                    if (!i_enable) begin
                        state      <= IDLE;
                        o_digit_en <= ALL_OFF;
                    end else if (cnt == BLANK_LAST) begin
                        state      <= DRIVE;
                        cnt        <= '0;
                        o_digit_en <= drive_en;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DRIVE: begin
                    if (!i_enable) begin
                        state      <= IDLE;
                        o_digit_en <= ALL_OFF;
                    end else if (cnt == DWELL_LAST) begin
                        state      <= BLANK;
                        cnt        <= '0;
                        index      <= index_next;
                        o_digit_en <= ALL_OFF;
                        if (frame_end) begin
                            shadow        <= shadow_upd;
                            o_load_ack    <= upd_ack;
                            pending_valid <= 1'b0;
                            o_frame_start <= 1'b1;
                            o_digit_value <= nibble(shadow_upd, '0);
                        end else begin
                            o_digit_value <= nibble(shadow, index_next);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    o_digit_en <= ALL_OFF;
                end
            endcase

            // Loads seen while scanning (including the cycle enable drops)
            // are parked in pending; IDLE or the next frame end moves them on.
            if (state != IDLE && i_load && !frame_end) begin
                pending       <= i_value;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
module tb_seven_segment_scan_ctrl;

    localparam int N     = 2;
    localparam int DWELL = 4;
    localparam int BLNK  = 2;
    localparam int SLOT  = BLNK + DWELL;
    localparam int FRAME = N * SLOT;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   value = 8'h00;
    logic         load = 1'b0;
    logic         enable = 1'b0;
    logic         load_ack;
    logic [3:0]   digit_value;
    logic [1:0]   digit_en;
    logic         frame_start;

    int checks = 0;
    int errors = 0;

    seven_segment_scan_ctrl #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLNK)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_value      (value),
        .i_load       (load),
        .i_enable     (enable),
        .o_load_ack   (load_ack),
        .o_digit_value(digit_value),
        .o_digit_en   (digit_en),
        .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    // Reference model: the scan is a position within a frame of FRAME
    // cycles; digit and blank/lit phase follow from arithmetic on it.
    bit m_run;
    int m_pos;
    int m_shadow;
    int m_pending;
    bit m_pv;
    bit m_ack;
    bit m_fs;
    int m_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_pos = 0; m_shadow = 0; m_pending = 0;
            m_pv = 0; m_ack = 0; m_fs = 0; m_val = 0;
        end else begin
            m_ack = 0;
            m_fs  = 0;
            if (!m_run) begin
                if (load) begin
                    m_shadow = int'(value); m_ack = 1; m_pv = 0;
                end else if (m_pv) begin
                    m_shadow = m_pending; m_ack = 1; m_pv = 0;
                end
                if (enable) begin
                    m_run = 1; m_pos = 0; m_fs = 1;
                end
            end else if (!enable) begin
                if (load) begin
                    m_pending = int'(value); m_pv = 1;
                end
                m_run = 0;
            end else if (m_pos == FRAME - 1) begin
                if (load) m_shadow = int'(value);
                else if (m_pv) m_shadow = m_pending;
                m_ack = load | m_pv;
                m_pv  = 0;
                m_pos = 0;
                m_fs  = 1;
            end else begin
                if (load) begin
                    m_pending = int'(value); m_pv = 1;
                end
                m_pos++;
            end
            if (m_run) m_val = (m_shadow >> (4 * (m_pos / SLOT))) & 'hF;
        end
    end

    function automatic int model_en();
        int d;
        if (!m_run || (m_pos % SLOT) < BLNK) return 3;
        d = m_pos / SLOT;
        if (LZ && d > 0 && (m_shadow >> (4 * d)) == 0) return 3;
        return (~(1 << d)) & 3;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("model_ack",   int'(load_ack),    int'(m_ack));
            check("model_fs",    int'(frame_start), int'(m_fs));
            check("model_value", int'(digit_value), m_val);
            check("model_en",    int'(digit_en),    model_en());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] en_tbl [12];
        int acks;
        bit found;
        en_tbl = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10,
                   2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};

        // Reset, asserted between clock edges
        #1 rst = 1'b1;
        #1;
        check("rst_en",    int'(digit_en),    3);
        check("rst_value", int'(digit_value), 0);
        check("rst_ack",   int'(load_ack),    0);
        check("rst_fs",    int'(frame_start), 0);
        ticks(2);
        rst = 1'b0;

        // 1: basic scan
        value = 8'h3A; load = 1'b1;
        tick();
        check("s1_ack", int'(load_ack), 1);
        load = 1'b0;
        tick();
        check("s1_ack_clr", int'(load_ack), 0);
        enable = 1'b1;
        tick();
        for (int i = 0; i < FRAME; i++) begin
            check("s1_en",    int'(digit_en),    int'(en_tbl[i]));
            check("s1_value", int'(digit_value), (i < SLOT) ? 'hA : 'h3);
            check("s1_fs",    int'(frame_start), (i == 0) ? 1 : 0);
            if (i < FRAME - 1) tick();
        end
        tick();
        check("s1_fs_next",  int'(frame_start), 1);
        check("s1_ack_next", int'(load_ack),    0);

        // 2: double buffering, two loads mid-frame
        value = 8'h11; load = 1'b1;
        tick();
        value = 8'h22;
        tick();
        load = 1'b0;
        acks = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            acks += int'(load_ack);
        end
        check("s2_no_early_ack", acks, 0);
        check("s2_old_value",    int'(digit_value), 'h3);
        tick();
        check("s2_fs",    int'(frame_start), 1);
        check("s2_ack",   int'(load_ack),    1);
        check("s2_value", int'(digit_value), 'h2);
        ticks(8);
        check("s2_value_d1", int'(digit_value), 'h2);
        check("s2_en_d1",    int'(digit_en),    2'b01);

        // 3: load in the last DRIVE cycle of digit 1
        ticks(3);
        value = 8'h77; load = 1'b1;
        tick();
        load = 1'b0;
        check("s3_fs",    int'(frame_start), 1);
        check("s3_ack",   int'(load_ack),    1);
        check("s3_value", int'(digit_value), 'h7);

        // 4: pending load, then enable drop in third DRIVE cycle of digit 0
        ticks(3);
        value = 8'h45; load = 1'b1;
        tick();
        load = 1'b0; enable = 1'b0;
        check("s4_en_drive", int'(digit_en), 2'b10);
        tick();
        check("s4_en_off", int'(digit_en), 2'b11);
        check("s4_no_ack", int'(load_ack), 0);
        tick();
        check("s4_idle_ack", int'(load_ack), 1);
        tick();
        check("s4_ack_clr", int'(load_ack),    0);
        check("s4_en_idle", int'(digit_en),    2'b11);
        check("s4_fs_idle", int'(frame_start), 0);
        enable = 1'b1;
        tick();
        check("s4_restart_fs",    int'(frame_start), 1);
        check("s4_restart_value", int'(digit_value), 'h5);
        ticks(2);
        check("s4_restart_en", int'(digit_en), 2'b10);

        // 5: asynchronous reset during DRIVE
        tick();
        #2;
        rst = 1'b1; enable = 1'b0;
        #1;
        check("s5_en",    int'(digit_en),    2'b11);
        check("s5_value", int'(digit_value), 0);
        check("s5_ack",   int'(load_ack),    0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s5_idle_en", int'(digit_en),    2'b11);
            check("s5_idle_fs", int'(frame_start), 0);
        end
        enable = 1'b1;
        tick();
        check("s5_fs",    int'(frame_start), 1);
        check("s5_value", int'(digit_value), 0);

        // 6: leading-zero blanking with 0x05
        value = 8'h05; load = 1'b1;
        tick();
        load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (frame_start) found = 1'b1;
        end
        check("s6_frame_seen", int'(found), 1);
        check("s6_ack",     int'(load_ack),    1);
        check("s6_value0",  int'(digit_value), 'h5);
        ticks(2);
        check("s6_en0", int'(digit_en), 2'b10);
        ticks(4);
        check("s6_value1", int'(digit_value), 0);
        check("s6_blank1", int'(digit_en),    2'b11);
        ticks(2);
        check("s6_en1", int'(digit_en), LZ ? 2'b11 : 2'b01);
        ticks(4);
        check("s6_next_fs",  int'(frame_start), 1);
        check("s6_next_ack", int'(load_ack),    0);
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
